miriscv_mdu_iter: RTL and testbench

Parametrised iterative multiply/divide unit for the miriscv execute stage, successor to the single-cycle-multiply MDU. Implements the RV32M/RV64M operations with a configurable-radix shift-add multiplier and a radix-2 restoring divider behind one shared FSM. Adds three fast paths that complete without stalling: divide-by-zero, signed overflow, and a result cache for paired MULH*/MUL and DIV/REM sequences on identical operands. Uses the existing req/stall/kill/keep pipeline protocol.

---
 rtl/miriscv_mdu_iter.sv | 207 ++++++++++++++++++++
 tb/tb_miriscv_mdu_iter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/miriscv_mdu_iter.sv
// rtl/miriscv_mdu_iter.sv - iterative RV32M/RV64M multiply/divide unit with fast paths and result cache
// Shift-add multiplier and radix-2 restoring divider share one FSM and one 2*XLEN accumulator.

module miriscv_mdu_iter #(
   parameter int XLEN     = 32,
   parameter int MUL_BITS = 4,
   parameter int MDU_OP_W = 3
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                mdu_req_i,
   input  logic [XLEN-1:0]     mdu_port_a_i,
   input  logic [XLEN-1:0]     mdu_port_b_i,
   input  logic [MDU_OP_W-1:0] mdu_op_i,
   input  logic                mdu_kill_i,
   input  logic                mdu_keep_i,
   output logic [XLEN-1:0]     mdu_result_o,
   output logic                mdu_stall_req_o
);

   localparam int                  CNT_W    = $clog2(XLEN + 1);
   localparam logic [CNT_W-1:0]    MUL_LAST = CNT_W'(XLEN / MUL_BITS - 1);
   localparam logic [CNT_W-1:0]    DIV_LAST = CNT_W'(XLEN - 1);
   localparam logic [MDU_OP_W-1:0] OP_MUL   = '0;
   localparam logic [XLEN-1:0]     MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [1:0]          CLS_MUL  = 2'd0;
   localparam logic [1:0]          CLS_SDIV = 2'd1;
   localparam logic [1:0]          CLS_UDIV = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [XLEN-1:0]       opnd_q, opnd_d;
   logic [2*XLEN-1:0]     acc_q, acc_d;
   logic                  neg_q, neg_d;
   logic                  neg_rem_q, neg_rem_d;
   logic [MDU_OP_W-1:0]   op_q, op_d;
   logic                  cache_valid_q, cache_valid_d;
   logic [XLEN-1:0]       cache_a_q, cache_a_d;
   logic [XLEN-1:0]       cache_b_q, cache_b_d;
   logic [1:0]            cache_cls_q, cache_cls_d;
   logic [2*XLEN-1:0]     cache_val_q, cache_val_d;

   logic                  is_div, is_rem, a_neg, b_neg;
   logic [XLEN-1:0]       a_mag, b_mag, fast_val;
   logic [1:0]            op_cls;
   logic                  div_zero, div_ovf, cache_hit, fast_hit, start, last;
   logic [XLEN+MUL_BITS-1:0] mul_part, mul_sum;
   logic [2*XLEN-1:0]     mul_step, mul_fin, div_step, div_fin;
   logic [XLEN:0]         div_shift, div_diff;
   logic                  div_ge;

   // Low half of the register is the product / quotient, high half the high product / remainder.
   function automatic logic [XLEN-1:0] sel_res(input logic [MDU_OP_W-1:0] op,
                                               input logic [2*XLEN-1:0] val);
      logic [XLEN-1:0] r;
      if (op[2])
         r = op[1] ? val[2*XLEN-1:XLEN] : val[XLEN-1:0];
      else
         r = (op == OP_MUL) ? val[XLEN-1:0] : val[2*XLEN-1:XLEN];
      return r;
   endfunction

   always_comb begin
      is_div   = mdu_op_i[2];
      is_rem   = mdu_op_i[1];
      a_neg    = mdu_port_a_i[XLEN-1] & (is_div ? ~mdu_op_i[0] : (mdu_op_i[1:0] != 2'b11));
      b_neg    = mdu_port_b_i[XLEN-1] & (is_div ? ~mdu_op_i[0] : ~mdu_op_i[1]);
      a_mag    = a_neg ? -mdu_port_a_i : mdu_port_a_i;
      b_mag    = b_neg ? -mdu_port_b_i : mdu_port_b_i;
      op_cls   = !is_div ? CLS_MUL : (mdu_op_i[0] ? CLS_UDIV : CLS_SDIV);
      div_zero = is_div & (mdu_port_b_i == '0);
      div_ovf  = is_div & ~mdu_op_i[0] & (mdu_port_a_i == MIN_INT) & (mdu_port_b_i == '1);
      // Only MUL reuses a cached product: its low half does not depend on operand signedness.
      cache_hit = cache_valid_q & (mdu_port_a_i == cache_a_q) & (mdu_port_b_i == cache_b_q)
                & (op_cls == cache_cls_q) & (is_div | (mdu_op_i == OP_MUL));
      fast_val = '0;
      if (div_zero)
         fast_val = is_rem ? mdu_port_a_i : '1;
      else if (div_ovf)
         fast_val = is_rem ? '0 : MIN_INT;
      else if (cache_hit)
         fast_val = sel_res(mdu_op_i, cache_val_q);
      fast_hit = div_zero | div_ovf | cache_hit;
      start    = (state_q == S_IDLE) & mdu_req_i & ~mdu_kill_i & ~fast_hit;
   end

   always_comb begin
      mul_part  = (XLEN+MUL_BITS)'(opnd_q) * (XLEN+MUL_BITS)'(acc_q[MUL_BITS-1:0]);
      mul_sum   = (XLEN+MUL_BITS)'(acc_q[2*XLEN-1:XLEN]) + mul_part;
      mul_step  = (2*XLEN)'({mul_sum, acc_q[XLEN-1:0]} >> MUL_BITS);
      mul_fin   = neg_q ? -mul_step : mul_step;
      div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      div_ge    = ~div_diff[XLEN];
      div_step  = {div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
      div_fin   = {neg_rem_q ? -div_step[2*XLEN-1:XLEN] : div_step[2*XLEN-1:XLEN],
                   neg_q     ? -div_step[XLEN-1:0]      : div_step[XLEN-1:0]};
      last      = ((state_q == S_MUL) & (cnt_q == MUL_LAST))
                | ((state_q == S_DIV) & (cnt_q == DIV_LAST));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:       if (start) state_d = is_div ? S_DIV : S_MUL;
         S_MUL, S_DIV: if (last) state_d = S_DONE;
         S_DONE:       if (!mdu_keep_i) state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
      if (mdu_kill_i)
         state_d = S_IDLE;
   end

   always_comb begin
      mdu_stall_req_o = 1'b0;
      mdu_result_o    = '0;
      if (!mdu_kill_i) begin
         case (state_q)
            S_IDLE: begin
               if (mdu_req_i) begin
                  mdu_stall_req_o = ~fast_hit;
                  mdu_result_o    = fast_val;
               end
            end
            S_MUL, S_DIV: mdu_stall_req_o = 1'b1;
            S_DONE:       if (mdu_req_i) mdu_result_o = sel_res(op_q, acc_q);
            default:      mdu_stall_req_o = 1'b0;
         endcase
      end
   end

   always_comb begin
      cnt_d         = cnt_q;
      opnd_d        = opnd_q;
      acc_d         = acc_q;
      neg_d         = neg_q;
      neg_rem_d     = neg_rem_q;
      op_d          = op_q;
      cache_valid_d = cache_valid_q;
      cache_a_d     = cache_a_q;
      cache_b_d     = cache_b_q;
      cache_cls_d   = cache_cls_q;
      cache_val_d   = cache_val_q;
      if (start) begin
         opnd_d    = is_div ? b_mag : a_mag;
         acc_d     = {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
         neg_d     = a_neg ^ b_neg;
         neg_rem_d = a_neg;
         op_d      = mdu_op_i;
         cnt_d     = '0;
      end else if (state_q == S_MUL) begin
         acc_d = last ? mul_fin : mul_step;
         cnt_d = cnt_q + CNT_W'(1);
      end else if (state_q == S_DIV) begin
         acc_d = last ? div_fin : div_step;
         cnt_d = cnt_q + CNT_W'(1);
      end
      // Operands are still held stable by the pipeline on the last iteration.
      if (last && !mdu_kill_i) begin
         cache_valid_d = 1'b1;
         cache_a_d     = mdu_port_a_i;
         cache_b_d     = mdu_port_b_i;
         cache_cls_d   = !op_q[2] ? CLS_MUL : (op_q[0] ? CLS_UDIV : CLS_SDIV);
         cache_val_d   = (state_q == S_MUL) ? mul_fin : div_fin;
      end
      if (mdu_kill_i)
         cache_valid_d = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q         <= '0;
         opnd_q        <= '0;
         acc_q         <= '0;
         neg_q         <= 1'b0;
         neg_rem_q     <= 1'b0;
         op_q          <= '0;
         cache_valid_q <= 1'b0;
         cache_a_q     <= '0;
         cache_b_q     <= '0;
         cache_cls_q   <= '0;
         cache_val_q   <= '0;
      end else begin
         cnt_q         <= cnt_d;
         opnd_q        <= opnd_d;
         acc_q         <= acc_d;
         neg_q         <= neg_d;
         neg_rem_q     <= neg_rem_d;
         op_q          <= op_d;
         cache_valid_q <= cache_valid_d;
         cache_a_q     <= cache_a_d;
         cache_b_q     <= cache_b_d;
         cache_cls_q   <= cache_cls_d;
         cache_val_q   <= cache_val_d;
      end
   end

endmodule

// File: tb/tb_miriscv_mdu_iter.sv
// tb/tb_miriscv_mdu_iter.sv - directed and random checks of miriscv_mdu_iter against an arithmetic model
// Expected results come from RV32M arithmetic; expected stall counts from fast-path/cache rules.

module tb_miriscv_mdu_iter;

   localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
   localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

   logic        clk = 1'b0;
   logic        rst, req, kill, keep, stall;
   logic [31:0] a, b, result;
   logic [2:0]  op;
   int          checks = 0;
   int          failures = 0;

   bit          cv;
   logic [31:0] ca, cb;
   logic [2:0]  cop;

   always #5 clk = ~clk;

   miriscv_mdu_iter #(.XLEN(32), .MUL_BITS(4), .MDU_OP_W(3)) dut (
      .clk_i(clk), .rst_i(rst), .mdu_req_i(req), .mdu_port_a_i(a), .mdu_port_b_i(b),
      .mdu_op_i(op), .mdu_kill_i(kill), .mdu_keep_i(keep),
      .mdu_result_o(result), .mdu_stall_req_o(stall)
   );

   function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      logic signed [63:0] sx, sy, uy_s;
      logic [63:0]        ux, uy, p;
      int                 ix, iy;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      ux = {32'b0, x};
      uy = {32'b0, y};
      uy_s = uy;
      ix = $signed(x);
      iy = $signed(y);
      case (o)
         OP_MUL:    begin p = ux * uy; return p[31:0]; end
         OP_MULH:   begin p = sx * sy; return p[63:32]; end
         OP_MULHSU: begin p = sx * uy_s; return p[63:32]; end
         OP_MULHU:  begin p = ux * uy; return p[63:32]; end
         OP_DIV:    return (y == 0) ? 32'hFFFFFFFF : (x == 32'h80000000 && y == 32'hFFFFFFFF) ? x : 32'(ix / iy);
         OP_REM:    return (y == 0) ? x : (x == 32'h80000000 && y == 32'hFFFFFFFF) ? 32'h0 : 32'(ix % iy);
         OP_DIVU:   return (y == 0) ? 32'hFFFFFFFF : x / y;
         default:   return (y == 0) ? x : x % y;
      endcase
   endfunction

   function automatic int ref_stalls(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      bit fast, hit;
      fast = o[2] && (y == 0 || (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF));
      hit  = cv && x == ca && y == cb && ((o == OP_MUL && !cop[2]) || (o[2] && cop[2] && o[0] == cop[0]));
      if (fast || hit) return 0;
      return o[2] ? 33 : 9;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int stalls, output logic [31:0] res, output bit done);
      req = 1'b1; op = o; a = x; b = y;
      stalls = 0; res = '0; done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (!stall) begin
            done = 1'b1;
            res  = result;
         end else begin
            stalls++;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic do_chk(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int exp_st, input logic [31:0] exp_r);
      int          st;
      logic [31:0] r;
      bit          done;
      run_op(o, x, y, st, r, done);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_stall"}, st, exp_st);
      chk({tag, "_res"}, r, exp_r);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFFFFFF;
         2: return 32'h80000000;
         3: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] ra, rb, rr;
      logic [2:0]  ro;
      int          est, st;
      bit          done;

      rst = 1'b1; req = 1'b0; kill = 1'b0; keep = 1'b0; op = '0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_stall", 32'(stall), 32'd0);
      chk("reset_result", result, 32'd0);
      @(posedge clk); #1;

      do_chk("mulhu", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 9, 32'hFFFFFFFE);
      do_chk("mul_hit", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h00000001);
      do_chk("div", OP_DIV, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD);
      do_chk("rem_hit", OP_REM, 32'hFFFFFFF9, 32'd2, 0, 32'hFFFFFFFF);
      do_chk("divu_zero", OP_DIVU, 32'd5, 32'd0, 0, 32'hFFFFFFFF);
      do_chk("remu_zero", OP_REMU, 32'd5, 32'd0, 0, 32'd5);
      do_chk("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000);
      do_chk("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 0, 32'h0);
      do_chk("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'd2, 9, 32'hFFFFFFFF);
      do_chk("mulh", OP_MULH, 32'h80000000, 32'h80000000, 9, 32'h40000000);

      req = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("kill_pre_stall", 32'(stall), 32'd1);
         @(posedge clk); #1;
      end
      kill = 1'b1;
      @(negedge clk);
      chk("kill_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      kill = 1'b0;
      do_chk("remu_after_kill", OP_REMU, 32'd100, 32'd7, 33, 32'd2);

      keep = 1'b1;
      do_chk("keep_mul", OP_MUL, 32'd3, 32'd7, 9, 32'd21);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("keep_stall", 32'(stall), 32'd0);
         chk("keep_result", result, 32'd21);
         @(posedge clk); #1;
      end
      req = 1'b0;
      @(negedge clk);
      chk("noreq_result", result, 32'd0);
      @(posedge clk); #1;
      keep = 1'b0;
      @(posedge clk); #1;
      do_chk("mul_hit2", OP_MUL, 32'd3, 32'd7, 0, 32'd21);

      req = 1'b1; op = OP_MULHU; a = 32'd3; b = 32'd7;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; req = 1'b0;
      @(negedge clk);
      chk("rst_mid_stall", 32'(stall), 32'd0);
      chk("rst_mid_result", result, 32'd0);
      @(posedge clk); #1;
      do_chk("mul_after_rst", OP_MUL, 32'd3, 32'd7, 9, 32'd21);

      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      cv = 1'b0; ca = '0; cb = '0; cop = '0;
      ra = pick(); rb = pick();
      for (int i = 0; i < 60; i++) begin
         ro = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 2) != 0) begin
            ra = pick();
            rb = pick();
         end
         est = ref_stalls(ro, ra, rb);
         run_op(ro, ra, rb, st, rr, done);
         chk($sformatf("rnd%0d_done", i), 32'(done), 32'd1);
         chk($sformatf("rnd%0d_op%0d_stall", i, ro), st, est);
         chk($sformatf("rnd%0d_op%0d_res", i, ro), rr, ref_res(ro, ra, rb));
         if (est != 0) begin
            cv = 1'b1; ca = ra; cb = rb; cop = ro;
         end
      end
      req = 1'b0;
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
